// File: rtl/cla_addsub_16bit_pkg.sv
// cla_addsub_16bit_pkg: shared width and saturation constants for the CLA add/sub path.
package cla_addsub_16bit_pkg;
    localparam int DATA_W = 16;
    localparam logic [DATA_W-1:0] SAT_POS = 16'h7FFF;
    localparam logic [DATA_W-1:0] SAT_NEG = 16'h8000;
endpackage

// File: rtl/cla_addsub_16bit_cla_4bit.sv
// cla_4bit: 4-bit carry-lookahead slice producing sum bits plus group generate/propagate.
module cla_4bit (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       cin,
    output logic [3:0] s,
    output logic       G,
    output logic       P
);
    logic [3:0] g, p, c;
    always_comb begin
        g = a & b;
        p = a ^ b;
        c[0] = cin;
        c[1] = g[0] | (p[0] & cin);
        c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
        c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & cin);
        s = p ^ c;
        G = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0]);
        P = &p;
    end
endmodule

// File: rtl/cla_addsub_16bit.sv
// cla_addsub_16bit: registered 16-bit signed saturating add/sub on a two-level CLA with N/Z/V/cout flags.
module cla_addsub_16bit
    import cla_addsub_16bit_pkg::*;
#(
    parameter int WIDTH = DATA_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             sub,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             N,
    output logic             Z,
    output logic             V
);
    logic [WIDTH-1:0] b_eff, r, sat;
    logic [3:0] gg, gp;
    logic [4:0] c;
    logic ovf;
    assign b_eff = b ^ {WIDTH{sub}};
    genvar i;
    generate
        for (i = 0; i < 4; i++) begin : g_slice
            cla_4bit u_cla (
                .a  (a[4*i+3:4*i]),
                .b  (b_eff[4*i+3:4*i]),
                .cin(c[i]),
                .s  (r[4*i+3:4*i]),
                .G  (gg[i]),
                .P  (gp[i])
            );
        end
    endgenerate
    // Second-level lookahead: every group carry is a flat function of c[0], no slice-to-slice ripple.
    always_comb begin
        c[0] = sub;
        c[1] = gg[0] | (gp[0] & c[0]);
        c[2] = gg[1] | (gp[1] & gg[0]) | (gp[1] & gp[0] & c[0]);
        c[3] = gg[2] | (gp[2] & gg[1]) | (gp[2] & gp[1] & gg[0]) | (gp[2] & gp[1] & gp[0] & c[0]);
        c[4] = gg[3] | (gp[3] & gg[2]) | (gp[3] & gp[2] & gg[1]) | (gp[3] & gp[2] & gp[1] & gg[0])
             | (gp[3] & gp[2] & gp[1] & gp[0] & c[0]);
        ovf = (a[WIDTH-1] == b_eff[WIDTH-1]) && (r[WIDTH-1] != a[WIDTH-1]);
        sat = ovf ? (a[WIDTH-1] ? SAT_NEG : SAT_POS) : r;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            sum  <= '0;
            cout <= 1'b0;
            N    <= 1'b0;
            Z    <= 1'b0;
            V    <= 1'b0;
        end else begin
            sum  <= sat;
            cout <= c[4];
            N    <= sat[WIDTH-1];
            Z    <= (sat == '0);
            V    <= ovf;
        end
    end
endmodule

// File: tb/tb_cla_addsub_16bit.sv
// tb_cla_addsub_16bit: table-driven directed checks of the saturating CLA add/sub, plus reset and hold sequences.
module tb_cla_addsub_16bit;
    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] a, b;
    logic        sub;
    logic [15:0] sum;
    logic        cout, N, Z, V;
    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic        sub;
        logic [15:0] sum;
        logic        cout;
        logic        n;
        logic        z;
        logic        v;
    } vec_t;

    vec_t vecs[14];

    cla_addsub_16bit dut (
        .clk (clk),
        .rst (rst),
        .a   (a),
        .b   (b),
        .sub (sub),
        .sum (sum),
        .cout(cout),
        .N   (N),
        .Z   (Z),
        .V   (V)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [15:0] es, input logic ec, en, ez, ev);
        checks++;
        if ({sum, cout, N, Z, V} !== {es, ec, en, ez, ev}) begin
            errors++;
            $display("FAIL %s: got sum=%h cout=%b N=%b Z=%b V=%b, want sum=%h cout=%b N=%b Z=%b V=%b",
                     name, sum, cout, N, Z, V, es, ec, en, ez, ev);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        vecs[0]  = '{16'd20000, 16'd10000, 1'b0, 16'd30000, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[1]  = '{16'd20000, 16'd10000, 1'b1, 16'd10000, 1'b1, 1'b0, 1'b0, 1'b0};
        vecs[2]  = '{16'd32767, 16'd100,   1'b0, 16'h7FFF,  1'b0, 1'b0, 1'b0, 1'b1};
        vecs[3]  = '{16'h8001,  16'hFB2E,  1'b0, 16'h8000,  1'b1, 1'b1, 1'b0, 1'b1};
        vecs[4]  = '{16'h1234,  16'h1234,  1'b1, 16'h0000,  1'b1, 1'b0, 1'b1, 1'b0};
        vecs[5]  = '{16'h0000,  16'h8000,  1'b1, 16'h7FFF,  1'b0, 1'b0, 1'b0, 1'b1};
        vecs[6]  = '{16'h8000,  16'h8000,  1'b1, 16'h0000,  1'b1, 1'b0, 1'b1, 1'b0};
        vecs[7]  = '{16'h7FFF,  16'h0001,  1'b0, 16'h7FFF,  1'b0, 1'b0, 1'b0, 1'b1};
        vecs[8]  = '{16'h8000,  16'hFFFF,  1'b0, 16'h8000,  1'b1, 1'b1, 1'b0, 1'b1};
        vecs[9]  = '{16'h7FFF,  16'hFFFF,  1'b0, 16'h7FFE,  1'b1, 1'b0, 1'b0, 1'b0};
        vecs[10] = '{16'hFFFF,  16'h0001,  1'b0, 16'h0000,  1'b1, 1'b0, 1'b1, 1'b0};
        vecs[11] = '{16'h0005,  16'h0007,  1'b1, 16'hFFFE,  1'b0, 1'b1, 1'b0, 1'b0};
        vecs[12] = '{16'h1234,  16'h0000,  1'b0, 16'h1234,  1'b0, 1'b0, 1'b0, 1'b0};
        vecs[13] = '{16'h0F0F,  16'h00F1,  1'b0, 16'h1000,  1'b0, 1'b0, 1'b0, 1'b0};

        rst = 1'b1; a = 16'd5; b = 16'd7; sub = 1'b0;
        step();
        check("reset", 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0);
        rst = 1'b0;
        step();
        check("post_reset_add", 16'd12, 1'b0, 1'b0, 1'b0, 1'b0);

        // New operands every cycle: each result must land exactly one edge after its inputs.
        for (int i = 0; i < 14; i++) begin
            a = vecs[i].a; b = vecs[i].b; sub = vecs[i].sub;
            step();
            check($sformatf("vec%0d", i), vecs[i].sum, vecs[i].cout, vecs[i].n, vecs[i].z, vecs[i].v);
        end

        a = 16'h8001; b = 16'hFB2E; sub = 1'b0;
        #2;
        check("hold_no_comb_path", 16'h1000, 1'b0, 1'b0, 1'b0, 1'b0);
        step();
        check("hold_then_update", 16'h8000, 1'b1, 1'b1, 1'b0, 1'b1);

        a = 16'h7FFF; b = 16'h0001; sub = 1'b0; rst = 1'b1;
        step();
        check("midstream_reset", 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0);
        rst = 1'b0; a = 16'd3; b = 16'd4; sub = 1'b1;
        step();
        check("after_midstream_reset", 16'hFFFF, 1'b0, 1'b1, 1'b0, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
